// File: rtl/prt_pkg.sv
// Shared definitions for the packet reference table (PRT) memory.
//   prt_state_e        : init-sequencer states.
//   PRT_RD_LAT_MIN/MAX : legal read-latency range; checked at elaboration.
//   PRT_*_DEF          : default widths shared with the lookup logic.
package prt_pkg;

  typedef enum logic {
    PRT_INIT  = 1'b0,
    PRT_READY = 1'b1
  } prt_state_e;

  localparam int unsigned PRT_RD_LAT_MIN = 1;
  localparam int unsigned PRT_RD_LAT_MAX = 2;

  localparam int unsigned PRT_DATA_W_DEF = 1;
  localparam int unsigned PRT_ADDR_W_DEF = 16;

  function automatic bit prt_rd_lat_ok(input int unsigned lat);
    return (lat >= PRT_RD_LAT_MIN) && (lat <= PRT_RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/prt_mem_core.sv
// Plain simple-dual-port array: one write port, one registered read port.
// No reset and no forwarding so it maps onto block RAM; a same-edge
// write/read to one address returns the old contents.
//   clk     : clock
//   we_i    : write enable,  waddr_i / wdata_i : write address / data
//   re_i    : read enable,   raddr_i           : read address
//   rdata_o : registered read data, updated only on re_i
module prt_mem_core
  import prt_pkg::*;
#(
  parameter int unsigned DATA_W = PRT_DATA_W_DEF,
  parameter int unsigned ADDR_W = PRT_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage write and registered read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prt_table_ram.sv
// Packet reference table memory with init sequencer, write-first
// collision forwarding and a 1- or 2-cycle read pipeline.
//   clk, rst              : clock, synchronous active-high reset
//   clear                 : re-init request (ignored while busy)
//   busy                  : init sweep running, table inaccessible
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr         : read launch
//   rd_valid/rd_data      : read result; rd_data holds when not valid
module prt_table_ram
  import prt_pkg::*;
#(
  parameter int unsigned       DATA_W   = PRT_DATA_W_DEF,
  parameter int unsigned       ADDR_W   = PRT_ADDR_W_DEF,
  parameter int unsigned       RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  if (!prt_rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $fatal(1, "prt_table_ram: RD_LAT must be 1 or 2");
  end

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  prt_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              user_we;
  logic              rd_launch;
  logic [DATA_W-1:0] mem_rdata;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRT_INIT;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: the sweep ends on terminal count, the pointer never wraps.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      PRT_INIT: begin
        if (ptr_q == PTR_LAST) begin
          state_d = PRT_READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      PRT_READY: begin
        if (clear) begin
          state_d = PRT_INIT;
          ptr_d   = '0;
        end
      end
      default: ;
    endcase
    busy_d = (state_d == PRT_INIT);
  end

  // Outputs: write mux (sweep vs. user) and read launch; clear drops user ops.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    user_we   = 1'b0;
    rd_launch = 1'b0;
    unique case (state_q)
      PRT_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = INIT_VAL;
      end
      PRT_READY: begin
        user_we   = wr_en & ~clear;
        rd_launch = rd_en & ~clear;
        mem_we    = user_we;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
      end
      default: ;
    endcase
  end

  prt_mem_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .re_i   (rd_launch),
    .raddr_i(rd_addr),
    .rdata_o(mem_rdata)
  );

  // Stage 1: capture the collision decision with the launch so the array
  // keeps plain read-old semantics; have_q forces zero data after reset.
  logic              v1_q;
  logic              have_q;
  logic              fwd_hit_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [DATA_W-1:0] stage1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      have_q     <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      v1_q <= rd_launch;
      if (rd_launch) begin
        have_q     <= 1'b1;
        fwd_hit_q  <= user_we && (wr_addr == rd_addr);
        fwd_data_q <= wr_data;
      end
    end
  end

  assign stage1_data = !have_q   ? '0 :
                       fwd_hit_q ? fwd_data_q : mem_rdata;

  if (RD_LAT == 2) begin : g_out_reg
    logic              v2_q;
    logic [DATA_W-1:0] out_q;

    // Optional output register; loads only on a valid stage-1 result.
    always_ff @(posedge clk) begin
      if (rst) begin
        v2_q  <= 1'b0;
        out_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          out_q <= stage1_data;
        end
      end
    end

    assign rd_valid = v2_q;
    assign rd_data  = out_q;
  end else begin : g_no_out_reg
    assign rd_valid = v1_q;
    assign rd_data  = stage1_data;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_prt_table_ram.sv
// Directed bench: one RD_LAT=1 and one RD_LAT=2 instance driven in lockstep.
module tb_prt_table_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_addr;

  logic       busy1, rv1, busy2, rv2;
  logic [7:0] rd1, rd2;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model [16];
  logic [3:0] b_addr [4];
  logic [7:0] b_exp  [4];

  always #5 clk = ~clk;

  prt_table_ram #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .INIT_VAL(8'h5A)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv1), .rd_data(rd1)
  );

  prt_table_ram #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2), .INIT_VAL(8'h5A)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv2), .rd_data(rd2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    model[a] = d;
  endtask

  task automatic model_init();
    for (int i = 0; i < 16; i++) model[i] = 8'h5A;
  endtask

  // Counts cycles with busy high, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy1 === 1'b1 && n < 64) begin
      n++;
      tick();
    end
  endtask

  // Back-to-back reads of every entry compared against the model.
  task automatic test_readback(input string tag);
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        rd_en = 1'b1; rd_addr = 4'(i);
      end else begin
        rd_en = 1'b0;
      end
      tick();
      if (i < 16) begin
        checks++;
        if (rv1 !== 1'b1 || rd1 !== model[i]) begin
          failures++;
          $display("FAIL %s lat1 addr %0d: valid=%b data=%h, expected valid=1 data=%h",
                   tag, i, rv1, rd1, model[i]);
        end
      end
      if (i > 0) begin
        checks++;
        if (rv2 !== 1'b1 || rd2 !== model[i-1]) begin
          failures++;
          $display("FAIL %s lat2 addr %0d: valid=%b data=%h, expected valid=1 data=%h",
                   tag, i-1, rv2, rd2, model[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1 || rv1 !== 1'b0 || rv2 !== 1'b0 ||
        rd1 !== 8'h00 || rd2 !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: busy=%b/%b valid=%b/%b data=%h/%h, expected busy=1 valid=0 data=00",
               busy1, busy2, rv1, rv2, rd1, rd2);
    end
    rst = 1'b0;
    count_busy(n);
    checks++;
    if (n != 16 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL init_busy_len: cycles=%0d busy2=%b, expected 16 and 0", n, busy2);
    end
    model_init();
    test_readback("init_contents");
  endtask

  task automatic test_write_read();
    do_write(4'd3, 8'hA5);
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rv1 !== 1'b1 || rd1 !== 8'hA5 || rv2 !== 1'b0) begin
      failures++;
      $display("FAIL wr_rd lat1: valid=%b data=%h lat2_valid=%b, expected 1 A5 0", rv1, rd1, rv2);
    end
    tick();
    checks++;
    if (rv2 !== 1'b1 || rd2 !== 8'hA5 || rv1 !== 1'b0 || rd1 !== 8'hA5) begin
      failures++;
      $display("FAIL wr_rd lat2: valid=%b data=%h lat1 valid=%b data=%h, expected 1 A5 0 A5",
               rv2, rd2, rv1, rd1);
    end
  endtask

  task automatic test_collision();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h3C;
    rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    model[7] = 8'h3C;
    checks++;
    if (rv1 !== 1'b1 || rd1 !== 8'h3C) begin
      failures++;
      $display("FAIL collision lat1: valid=%b data=%h, expected 1 3C", rv1, rd1);
    end
    tick();
    checks++;
    if (rv2 !== 1'b1 || rd2 !== 8'h3C) begin
      failures++;
      $display("FAIL collision lat2: valid=%b data=%h, expected 1 3C", rv2, rd2);
    end
    // Write one cycle after the read launch must not leak into that read.
    rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'hFF;
    checks++;
    if (rv1 !== 1'b1 || rd1 !== 8'h3C) begin
      failures++;
      $display("FAIL late_write lat1: valid=%b data=%h, expected 1 3C", rv1, rd1);
    end
    tick();
    wr_en = 1'b0;
    model[7] = 8'hFF;
    checks++;
    if (rv2 !== 1'b1 || rd2 !== 8'h3C) begin
      failures++;
      $display("FAIL late_write lat2: valid=%b data=%h, expected 1 3C", rv2, rd2);
    end
    // Different addresses in the same cycle: no forwarding.
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 8'h11;
    rd_en = 1'b1; rd_addr = 4'd9;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    model[8] = 8'h11;
    checks++;
    if (rv1 !== 1'b1 || rd1 !== 8'h5A) begin
      failures++;
      $display("FAIL no_fwd lat1: valid=%b data=%h, expected 1 5A", rv1, rd1);
    end
    tick();
    checks++;
    if (rv2 !== 1'b1 || rd2 !== 8'h5A) begin
      failures++;
      $display("FAIL no_fwd lat2: valid=%b data=%h, expected 1 5A", rv2, rd2);
    end
    test_readback("after_collision");
  endtask

  task automatic test_boundary();
    do_write(4'd0, 8'h01);
    do_write(4'd15, 8'hFE);
    b_addr[0] = 4'd0;  b_exp[0] = 8'h01;
    b_addr[1] = 4'd15; b_exp[1] = 8'hFE;
    b_addr[2] = 4'd1;  b_exp[2] = 8'h5A;
    b_addr[3] = 4'd14; b_exp[3] = 8'h5A;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        rd_en = 1'b1; rd_addr = b_addr[k];
      end else begin
        rd_en = 1'b0;
      end
      tick();
      if (k < 4) begin
        checks++;
        if (rv1 !== 1'b1 || rd1 !== b_exp[k]) begin
          failures++;
          $display("FAIL boundary lat1 addr %0d: valid=%b data=%h, expected 1 %h",
                   b_addr[k], rv1, rd1, b_exp[k]);
        end
      end
      if (k > 0) begin
        checks++;
        if (rv2 !== 1'b1 || rd2 !== b_exp[k-1]) begin
          failures++;
          $display("FAIL boundary lat2 addr %0d: valid=%b data=%h, expected 1 %h",
                   b_addr[k-1], rv2, rd2, b_exp[k-1]);
        end
      end
    end
  endtask

  task automatic test_clear();
    int n;
    do_write(4'd2, 8'hC3);
    clear = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h77;
    tick();
    clear = 1'b0; wr_en = 1'b0;
    n = 0;
    while (busy1 === 1'b1 && n < 64) begin
      checks++;
      if (rv1 !== 1'b0 || rv2 !== 1'b0 || busy2 !== 1'b1) begin
        failures++;
        $display("FAIL clear_window cycle %0d: valid=%b/%b busy2=%b, expected 0/0 1",
                 n, rv1, rv2, busy2);
      end
      rd_en = 1'b1; rd_addr = 4'd2;
      n++;
      tick();
    end
    rd_en = 1'b0;
    checks++;
    if (n != 16 || rv1 !== 1'b0) begin
      failures++;
      $display("FAIL clear_busy_len: cycles=%0d valid1=%b, expected 16 and 0", n, rv1);
    end
    tick();
    checks++;
    if (rv2 !== 1'b0) begin
      failures++;
      $display("FAIL clear_tail lat2: valid=%b, expected 0", rv2);
    end
    model_init();
    test_readback("after_clear");
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    do_write(4'd12, 8'h99);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1 || rv1 !== 1'b0 || rv2 !== 1'b0) begin
      failures++;
      $display("FAIL mid_sweep_reset: busy=%b/%b valid=%b/%b, expected 1/1 0/0",
               busy1, busy2, rv1, rv2);
    end
    rst = 1'b0;
    count_busy(n);
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL mid_sweep_restart: cycles=%0d, expected 16", n);
    end
    model_init();
    test_readback("after_mid_sweep");
  endtask

  task automatic test_reset_inflight();
    int n;
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    rd_addr = 4'd5;
    tick();
    rd_en = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (rv1 !== 1'b0 || rv2 !== 1'b0 || rd1 !== 8'h00 || rd2 !== 8'h00 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL inflight_reset: valid=%b/%b data=%h/%h busy=%b, expected 0/0 00/00 1",
               rv1, rv2, rd1, rd2, busy1);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (rv2 !== 1'b0) begin
      failures++;
      $display("FAIL inflight_drain lat2: valid=%b, expected 0", rv2);
    end
    count_busy(n);
    checks++;
    if (n != 15) begin
      failures++;
      $display("FAIL inflight_restart: remaining cycles=%0d, expected 15", n);
    end
    test_readback("after_inflight");
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    model_init();
    tick();
    test_reset();
    test_write_read();
    test_collision();
    test_boundary();
    test_clear();
    test_reset_mid_sweep();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
